dual_port_ram: RTL and testbench

- Simple dual-port synchronous RAM: one write port, one read port, shared single clock.
- Default geometry: 4096 words x 64 bits.
- Storage block behind the memory-transaction verification environment.
- Write and read ports operate independently and concurrently every cycle.

---
 rtl/dual_port_ram_pkg.sv | 14 +
 rtl/dpram_mem_array.sv | 48 ++++
 rtl/dual_port_ram.sv | 51 +++++
 tb/tb_dual_port_ram.sv | 127 ++++++++++++
 4 files changed

// File: rtl/dual_port_ram_pkg.sv
// Shared geometry and types for the dual-port RAM.
//   DATA_W : word width in bits
//   ADDR_W : address width in bits
//   DEPTH  : number of words, always 2**ADDR_W so addresses never wrap or alias
package dual_port_ram_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage : dual_port_ram_pkg

// File: rtl/dpram_mem_array.sv
// Raw storage array with one write port and one registered read port.
// Written in the plain "one write process, one registered read" shape so
// synthesis maps it onto block RAM.
//   clk     : clock, all activity on the rising edge
//   clr     : synchronous clear of the read register only (contents kept)
//   wr_en   : write enable
//   wr_addr : write address
//   wr_data : write data
//   rd_en   : read enable; when low the read register holds its value
//   rd_addr : read address
//   rd_data : registered read data, valid one cycle after rd_en is sampled
module dpram_mem_array
  import dual_port_ram_pkg::*;
#(
  parameter int DATA_W = dual_port_ram_pkg::DATA_W,
  parameter int ADDR_W = dual_port_ram_pkg::ADDR_W,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Memory contents are never reset, which keeps the array RAM-inferable.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Both processes sample mem before the write lands at this edge, so a
  // same-address write and read on one edge returns the old contents.
  always_ff @(posedge clk) begin
    if (clr) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule : dpram_mem_array

// File: rtl/dual_port_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port, one clock.
// Both ports accept a new operation every cycle with no handshake.
//   clk    : clock, all activity on the rising edge
//   rst    : synchronous active-high reset; clears out, ignores that cycle's
//            write and read, leaves memory contents untouched
//   in     : write data
//   wr     : write enable
//   wr_add : write address
//   rd     : read enable; when low out holds its previous value
//   rd_add : read address
//   out    : registered read data (read-before-write on address collision)
module dual_port_ram
  import dual_port_ram_pkg::*;
#(
  parameter int DATA_W = dual_port_ram_pkg::DATA_W,
  parameter int ADDR_W = dual_port_ram_pkg::ADDR_W,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in,
  input  logic              wr,
  input  logic [ADDR_W-1:0] wr_add,
  input  logic              rd,
  input  logic [ADDR_W-1:0] rd_add,
  output logic [DATA_W-1:0] out
);

  logic wr_gated;
  logic rd_gated;

  // Reset discards whatever operations were presented on that edge.
  assign wr_gated = wr & ~rst;
  assign rd_gated = rd & ~rst;

  dpram_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .clr     (rst),
    .wr_en   (wr_gated),
    .wr_addr (wr_add),
    .wr_data (in),
    .rd_en   (rd_gated),
    .rd_addr (rd_add),
    .rd_data (out)
  );

endmodule : dual_port_ram

// File: tb/tb_dual_port_ram.sv
// Directed self-checking bench for dual_port_ram.
// Inputs are driven and outputs checked on the falling edge; each stimulus
// step spans exactly one rising edge.
module tb_dual_port_ram;
  import dual_port_ram_pkg::*;

  logic  clk;
  logic  rst;
  data_t in;
  logic  wr;
  addr_t wr_add;
  logic  rd;
  addr_t rd_add;
  data_t out;

  int compared   = 0;
  int mismatched = 0;

  dual_port_ram dut (
    .clk    (clk),
    .rst    (rst),
    .in     (in),
    .wr     (wr),
    .wr_add (wr_add),
    .rd     (rd),
    .rd_add (rd_add),
    .out    (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's inputs at the falling edge, then advance past one
  // rising edge to the next falling edge where out can be checked.
  task automatic applyStimulus(input logic r, input logic w, input addr_t wa,
                               input data_t d, input logic re, input addr_t ra);
    rst    = r;
    wr     = w;
    wr_add = wa;
    in     = d;
    rd     = re;
    rd_add = ra;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input data_t expected);
    compared++;
    assert (out === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: out=%h expected=%h", tag, out, expected);
    end
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0;
    in = '0; wr_add = '0; rd_add = '0;
    @(negedge clk);

    // Reset held two cycles with a read and a write attempt present.
    applyStimulus(1'b1, 1'b1, 12'd5, 64'hAA, 1'b1, 12'd5);
    checkOutput("reset_cycle1", 64'h0);
    applyStimulus(1'b1, 1'b1, 12'd5, 64'hAA, 1'b1, 12'd5);
    checkOutput("reset_cycle2", 64'h0);

    // Post-reset write with rd low: out holds zero.
    applyStimulus(1'b0, 1'b1, 12'd5, 64'h11, 1'b0, 12'd0);
    checkOutput("hold_after_reset", 64'h0);
    applyStimulus(1'b0, 1'b0, 12'd0, 64'h0, 1'b1, 12'd5);
    checkOutput("reset_write_ignored", 64'h11);

    // Boundary addresses.
    applyStimulus(1'b0, 1'b1, 12'h000, 64'h0123_4567_89AB_CDEF, 1'b0, 12'd0);
    applyStimulus(1'b0, 1'b1, 12'hFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 12'd0);
    applyStimulus(1'b0, 1'b0, 12'd0, 64'h0, 1'b1, 12'h000);
    checkOutput("read_addr_000", 64'h0123_4567_89AB_CDEF);
    applyStimulus(1'b0, 1'b0, 12'd0, 64'h0, 1'b1, 12'hFFF);
    checkOutput("read_addr_fff", 64'hFFFF_FFFF_FFFF_FFFF);

    // Same-address collision returns the old word; new word on next read.
    applyStimulus(1'b0, 1'b1, 12'h010, 64'h5, 1'b0, 12'd0);
    applyStimulus(1'b0, 1'b1, 12'h010, 64'h9, 1'b1, 12'h010);
    checkOutput("collision_old_data", 64'h5);
    applyStimulus(1'b0, 1'b0, 12'd0, 64'h0, 1'b1, 12'h010);
    checkOutput("collision_new_data", 64'h9);

    // Hold: rd low for 5 cycles while writing elsewhere.
    applyStimulus(1'b0, 1'b1, 12'd3, 64'hABCD, 1'b0, 12'd0);
    applyStimulus(1'b0, 1'b0, 12'd0, 64'h0, 1'b1, 12'd3);
    checkOutput("hold_initial_read", 64'hABCD);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, addr_t'(200 + i), data_t'(64'h7700 + i), 1'b0, 12'd3);
      checkOutput($sformatf("hold_cycle%0d", i), 64'hABCD);
    end

    // Mid-stream reset: clears out, drops that cycle's write, keeps memory.
    applyStimulus(1'b1, 1'b1, 12'h000, 64'hDEAD, 1'b1, 12'h000);
    checkOutput("midstream_reset_out", 64'h0);
    applyStimulus(1'b0, 1'b0, 12'd0, 64'h0, 1'b1, 12'h000);
    checkOutput("midstream_reset_mem_kept", 64'h0123_4567_89AB_CDEF);

    // Streaming writes then back-to-back reads.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, addr_t'(i), data_t'(i * 3), 1'b0, 12'd0);
    end
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b0, 12'd0, 64'h0, 1'b1, addr_t'(i));
      checkOutput($sformatf("stream_read%0d", i), data_t'(i * 3));
    end

    // Concurrent independent ports.
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b0, 1'b1, addr_t'(k), data_t'(k ^ 8'hFF), 1'b0, 12'd0);
    end
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b0, 1'b1, addr_t'(k + 100), data_t'(k), 1'b1, addr_t'(k));
      checkOutput($sformatf("concurrent_read%0d", k), data_t'(k ^ 8'hFF));
    end
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b0, 1'b0, 12'd0, 64'h0, 1'b1, addr_t'(k + 100));
      checkOutput($sformatf("concurrent_write%0d", k), data_t'(k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_dual_port_ram
